// File: rtl/vga_timing_gen_if.sv
// Pixel-side bus of vga_timing_gen: requester colour in, request coordinates out, DAC/VGA pins out.
// VGA_TEST_PATTERN_EN adds the pattern_sel input.
interface vga_timing_gen_if #(
  parameter int unsigned CW    = 10,
  parameter int unsigned IN_W  = 5,
  parameter int unsigned OUT_W = 8
);
  logic [IN_W-1:0]  red_in;
  logic [IN_W-1:0]  green_in;
  logic [IN_W-1:0]  blue_in;
`ifdef VGA_TEST_PATTERN_EN
  logic             pattern_sel;
`endif
  logic [CW-1:0]    x;
  logic [CW-1:0]    y;
  logic             pixel_req;
  logic             line_start;
  logic             frame_start;
  logic             vga_clk;
  logic             vga_sync;
  logic             vga_blank;
  logic             hsync;
  logic             vsync;
  logic [OUT_W-1:0] vga_red;
  logic [OUT_W-1:0] vga_green;
  logic [OUT_W-1:0] vga_blue;

  modport master (
    input  red_in, green_in, blue_in,
`ifdef VGA_TEST_PATTERN_EN
    input  pattern_sel,
`endif
    output x, y, pixel_req, line_start, frame_start,
    output vga_clk, vga_sync, vga_blank, hsync, vsync, vga_red, vga_green, vga_blue
  );

  modport slave (
    output red_in, green_in, blue_in,
`ifdef VGA_TEST_PATTERN_EN
    output pattern_sel,
`endif
    input  x, y, pixel_req, line_start, frame_start,
    input  vga_clk, vga_sync, vga_blank, hsync, vsync, vga_red, vga_green, vga_blue
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with fixed-latency colour pipeline for the DE1-SoC DAC.
// Optional VGA_TEST_PATTERN_EN: internal 8-bar colour pattern selected by pattern_sel.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter bit          HSYNC_POL   = 1'b0,
  parameter bit          VSYNC_POL   = 1'b0,
  parameter int unsigned IN_W        = 5,
  parameter int unsigned OUT_W       = 8,
  parameter int unsigned PIX_LATENCY = 1,
  parameter int unsigned CW          = 10
) (
  input  logic            clk,
  input  logic            reset_n,
  vga_timing_gen_if.master bus
);
  localparam int unsigned HTotal   = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal   = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned MaxTotal = (HTotal > VTotal) ? HTotal : VTotal;
  localparam int unsigned CntW     = (MaxTotal > 2) ? $clog2(MaxTotal + 1) : 1;
  localparam int unsigned RepW     = (OUT_W > IN_W) ? OUT_W - IN_W : 1;
  localparam int unsigned Lat      = PIX_LATENCY;

  localparam logic [CntW-1:0] HLast    = CntW'(HTotal - 1);
  localparam logic [CntW-1:0] HActEnd  = CntW'(H_ACTIVE);
  localparam logic [CntW-1:0] HSyncBeg = CntW'(H_ACTIVE + H_FRONT);
  localparam logic [CntW-1:0] HSyncEnd = CntW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CntW-1:0] VLast    = CntW'(VTotal - 1);
  localparam logic [CntW-1:0] VActEnd  = CntW'(V_ACTIVE);
  localparam logic [CntW-1:0] VSyncBeg = CntW'(V_ACTIVE + V_FRONT);
  localparam logic [CntW-1:0] VSyncEnd = CntW'(V_ACTIVE + V_FRONT + V_SYNC);

  logic            run_q, run_d;
  logic [CntW-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [Lat-1:0]  req_pipe_q, req_pipe_d, hs_pipe_q, hs_pipe_d, vs_pipe_q, vs_pipe_d;
  logic            blank_q, blank_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic [OUT_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic            pix_req, hs_act, vs_act, h_act, v_act;
  logic [OUT_W-1:0] red_exp, green_exp, blue_exp, red_src, green_src, blue_src;

  // Counting holds at 0,0 for the first edge after reset so the frame starts cleanly.
  always_comb begin
    run_d   = 1'b1;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (run_q) begin
      if (h_cnt_q == HLast) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    h_act           = h_cnt_q < HActEnd;
    v_act           = v_cnt_q < VActEnd;
    pix_req         = run_q & h_act & v_act;
    hs_act          = run_q & (h_cnt_q >= HSyncBeg) & (h_cnt_q < HSyncEnd);
    vs_act          = run_q & (v_cnt_q >= VSyncBeg) & (v_cnt_q < VSyncEnd);
    bus.pixel_req   = pix_req;
    bus.x           = pix_req ? CW'(h_cnt_q) : '0;
    bus.y           = pix_req ? CW'(v_cnt_q) : '0;
    bus.line_start  = run_q & (h_cnt_q == '0) & v_act;
    bus.frame_start = run_q & (h_cnt_q == '0) & (v_cnt_q == '0);
  end

  always_comb begin
    req_pipe_d[0] = pix_req;
    hs_pipe_d[0]  = hs_act;
    vs_pipe_d[0]  = vs_act;
    for (int i = 1; i < Lat; i++) begin
      req_pipe_d[i] = req_pipe_q[i-1];
      hs_pipe_d[i]  = hs_pipe_q[i-1];
      vs_pipe_d[i]  = vs_pipe_q[i-1];
    end
  end

  if (OUT_W == IN_W) begin : g_no_rep
    assign red_exp   = bus.red_in;
    assign green_exp = bus.green_in;
    assign blue_exp  = bus.blue_in;
  end else begin : g_rep
    assign red_exp   = {bus.red_in,   bus.red_in[IN_W-1 -: RepW]};
    assign green_exp = {bus.green_in, bus.green_in[IN_W-1 -: RepW]};
    assign blue_exp  = {bus.blue_in,  bus.blue_in[IN_W-1 -: RepW]};
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BarW = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  logic [CW-1:0] x_pipe_q [Lat];
  logic [CW-1:0] x_pipe_d [Lat];
  logic [CW-1:0] bar_full;
  logic [2:0]    bar;

  always_comb begin
    x_pipe_d[0] = bus.x;
    for (int i = 1; i < Lat; i++) x_pipe_d[i] = x_pipe_q[i-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < Lat; i++) x_pipe_q[i] <= '0;
    end else begin
      for (int i = 0; i < Lat; i++) x_pipe_q[i] <= x_pipe_d[i];
    end
  end

  // Bar index bits map straight to channels: white,yellow,cyan,green,magenta,red,blue,black.
  always_comb begin
    bar_full  = x_pipe_q[Lat-1] / CW'(BarW);
    bar       = bar_full[2:0];
    red_src   = bus.pattern_sel ? {OUT_W{~bar[1]}} : red_exp;
    green_src = bus.pattern_sel ? {OUT_W{~bar[2]}} : green_exp;
    blue_src  = bus.pattern_sel ? {OUT_W{~bar[0]}} : blue_exp;
  end
`else
  always_comb begin
    red_src   = red_exp;
    green_src = green_exp;
    blue_src  = blue_exp;
  end
`endif

  always_comb begin
    blank_d = req_pipe_q[Lat-1];
    hsync_d = hs_pipe_q[Lat-1] ? HSYNC_POL : ~HSYNC_POL;
    vsync_d = vs_pipe_q[Lat-1] ? VSYNC_POL : ~VSYNC_POL;
    red_d   = req_pipe_q[Lat-1] ? red_src   : '0;
    green_d = req_pipe_q[Lat-1] ? green_src : '0;
    blue_d  = req_pipe_q[Lat-1] ? blue_src  : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q      <= 1'b0;
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      req_pipe_q <= '0;
      hs_pipe_q  <= '0;
      vs_pipe_q  <= '0;
      blank_q    <= 1'b0;
      hsync_q    <= ~HSYNC_POL;
      vsync_q    <= ~VSYNC_POL;
      red_q      <= '0;
      green_q    <= '0;
      blue_q     <= '0;
    end else begin
      run_q      <= run_d;
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      req_pipe_q <= req_pipe_d;
      hs_pipe_q  <= hs_pipe_d;
      vs_pipe_q  <= vs_pipe_d;
      blank_q    <= blank_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      red_q      <= red_d;
      green_q    <= green_d;
      blue_q     <= blue_d;
    end
  end

  assign bus.vga_clk   = clk;
  assign bus.vga_sync  = 1'b0;
  assign bus.vga_blank = blank_q;
  assign bus.hsync     = hsync_q;
  assign bus.vsync     = vsync_q;
  assign bus.vga_red   = red_q;
  assign bus.vga_green = green_q;
  assign bus.vga_blue  = blue_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance plus a tiny-timing instance (latency 3, 4->8 bit colour).
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = -1;
  int   hs_low;
  int   ls_cnt;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.CW(10), .IN_W(5), .OUT_W(8)) if0 ();
  vga_timing_gen_if #(.CW(10), .IN_W(4), .OUT_W(8)) if1 ();

  vga_timing_gen u_dut0 (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (if0)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .IN_W(4), .OUT_W(8), .PIX_LATENCY(3), .CW(10)
  ) u_dut1 (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (if1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples on the falling edge; cyc counts clocks since counting started at 0,0.
  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic goto(input int target);
    while (cyc < target) step();
  endtask

  initial begin
    if0.red_in = '0; if0.green_in = '0; if0.blue_in = '0;
    if1.red_in = 4'b1010; if1.green_in = '0; if1.blue_in = 4'b0101;
`ifdef VGA_TEST_PATTERN_EN
    if0.pattern_sel = 1'b0;
    if1.pattern_sel = 1'b0;
`endif
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hsync", 32'(if0.hsync), 32'd1);
    check("rst_vsync", 32'(if0.vsync), 32'd1);
    check("rst_blank", 32'(if0.vga_blank), 32'd0);
    check("rst_red", 32'(if0.vga_red), 32'd0);
    check("rst_x", 32'(if0.x), 32'd0);
    check("rst_y", 32'(if0.y), 32'd0);
    check("rst_req", 32'(if0.pixel_req), 32'd0);
    check("rst_fs", 32'(if0.frame_start), 32'd0);
    check("rst1_blue", 32'(if1.vga_blue), 32'd0);
    check("vga_sync", 32'(if0.vga_sync), 32'd0);

    rst_n = 1'b1;
    step();
    check("c0_req", 32'(if0.pixel_req), 32'd1);
    check("c0_fs", 32'(if0.frame_start), 32'd1);
    check("c0_ls", 32'(if0.line_start), 32'd1);
    check("c0_x", 32'(if0.x), 32'd0);
    check("c0_req1", 32'(if1.pixel_req), 32'd1);
    check("c0_fs1", 32'(if1.frame_start), 32'd1);

    step();
    check("c1_x", 32'(if0.x), 32'd1);
    check("c1_blank", 32'(if0.vga_blank), 32'd0);
    check("c1_red", 32'(if0.vga_red), 32'd0);
    if0.red_in = 5'b10000;
    step();
    check("c2_red84", 32'(if0.vga_red), 32'h84);
    check("c2_blank", 32'(if0.vga_blank), 32'd1);
    check("c2_green", 32'(if0.vga_green), 32'd0);
    if0.red_in = '0;
    step();
    check("c3_red", 32'(if0.vga_red), 32'd0);
    check("c3_blank", 32'(if0.vga_blank), 32'd1);
    check("d1_c3_blank", 32'(if1.vga_blank), 32'd0);
    check("d1_c3_red", 32'(if1.vga_red), 32'd0);
    step();
    check("d1_c4_blank", 32'(if1.vga_blank), 32'd1);
    check("d1_c4_redAA", 32'(if1.vga_red), 32'hAA);
    check("d1_c4_blue55", 32'(if1.vga_blue), 32'h55);
    check("d1_c4_green", 32'(if1.vga_green), 32'd0);
    goto(7);
    check("d1_x7", 32'(if1.x), 32'd7);
    check("d1_req7", 32'(if1.pixel_req), 32'd1);
    goto(8);
    check("d1_req8", 32'(if1.pixel_req), 32'd0);
    check("d1_x8", 32'(if1.x), 32'd0);
    goto(11);
    check("d1_blank11", 32'(if1.vga_blank), 32'd1);
    check("d1_red11", 32'(if1.vga_red), 32'hAA);
    goto(12);
    check("d1_blank12", 32'(if1.vga_blank), 32'd0);
    check("d1_red12", 32'(if1.vga_red), 32'd0);
    goto(13);
    check("d1_hs13", 32'(if1.hsync), 32'd1);
    check("d1_ls13", 32'(if1.line_start), 32'd0);
    goto(14);
    check("d1_hs14", 32'(if1.hsync), 32'd0);
    check("d1_ls14", 32'(if1.line_start), 32'd1);
    goto(15);
    check("d1_hs15", 32'(if1.hsync), 32'd0);
    goto(16);
    check("d1_hs16", 32'(if1.hsync), 32'd1);
    goto(17);
    check("d1_x17", 32'(if1.x), 32'd3);
    check("d1_y17", 32'(if1.y), 32'd1);
    goto(56);
    check("d1_ls56", 32'(if1.line_start), 32'd0);
    check("d1_req56", 32'(if1.pixel_req), 32'd0);
    goto(73);
    check("d1_vs73", 32'(if1.vsync), 32'd1);
    goto(74);
    check("d1_vs74", 32'(if1.vsync), 32'd0);
    goto(87);
    check("d1_vs87", 32'(if1.vsync), 32'd0);
    goto(88);
    check("d1_vs88", 32'(if1.vsync), 32'd1);
    goto(97);
    check("d1_fs97", 32'(if1.frame_start), 32'd0);
    goto(98);
    check("d1_fs98", 32'(if1.frame_start), 32'd1);

    goto(639);
    check("x639", 32'(if0.x), 32'd639);
    check("req639", 32'(if0.pixel_req), 32'd1);
    goto(640);
    check("req640", 32'(if0.pixel_req), 32'd0);
    check("x640", 32'(if0.x), 32'd0);
    goto(641);
    check("blank641", 32'(if0.vga_blank), 32'd1);
    goto(642);
    check("blank642", 32'(if0.vga_blank), 32'd0);
    goto(657);
    check("hs657", 32'(if0.hsync), 32'd1);
    goto(658);
    check("hs658", 32'(if0.hsync), 32'd0);
    goto(753);
    check("hs753", 32'(if0.hsync), 32'd0);
    goto(754);
    check("hs754", 32'(if0.hsync), 32'd1);

    goto(800);
    hs_low = 0;
    ls_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      if (if0.hsync == 1'b0) hs_low++;
      if (if0.line_start == 1'b1) ls_cnt++;
      step();
    end
    check("hs_low_width", 32'(hs_low), 32'd96);
    check("ls_per_line", 32'(ls_cnt), 32'd1);
    check("ls1600", 32'(if0.line_start), 32'd1);
    check("vs_line2", 32'(if0.vsync), 32'd1);

    goto(1850);
    if0.red_in = 5'b11111;
    goto(1900);
    check("x300", 32'(if0.x), 32'd300);
    check("y2", 32'(if0.y), 32'd2);
    check("redFF", 32'(if0.vga_red), 32'hFF);

    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_red", 32'(if0.vga_red), 32'd0);
    check("mid_rst_blank", 32'(if0.vga_blank), 32'd0);
    check("mid_rst_x", 32'(if0.x), 32'd0);
    check("mid_rst_req", 32'(if0.pixel_req), 32'd0);
    check("mid_rst_hs", 32'(if0.hsync), 32'd1);
    if0.red_in = '0;
`ifdef VGA_TEST_PATTERN_EN
    if0.pattern_sel = 1'b1;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cyc = -1;
    step();
    check("rs_x", 32'(if0.x), 32'd0);
    check("rs_y", 32'(if0.y), 32'd0);
    check("rs_ls", 32'(if0.line_start), 32'd1);
    check("rs_fs", 32'(if0.frame_start), 32'd1);
    step();
    check("rs_x1", 32'(if0.x), 32'd1);

`ifdef VGA_TEST_PATTERN_EN
    goto(2);
    check("pat0", 32'({if0.vga_red, if0.vga_green, if0.vga_blue}), 32'hFFFFFF);
    goto(81);
    check("pat79", 32'({if0.vga_red, if0.vga_green, if0.vga_blue}), 32'hFFFFFF);
    goto(82);
    check("pat80", 32'({if0.vga_red, if0.vga_green, if0.vga_blue}), 32'hFFFF00);
    goto(562);
    check("pat560", 32'({if0.vga_red, if0.vga_green, if0.vga_blue}), 32'h000000);
    check("pat560_blank", 32'(if0.vga_blank), 32'd1);
    goto(641);
    check("pat639", 32'({if0.vga_red, if0.vga_green, if0.vga_blue}), 32'h000000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
